// File: rtl/systolic_tile_ctrl.sv
// systolic_tile_ctrl: sequences one tile through the NxN array.
// Phases are weight load, switch and stream, skew drain, then a done pulse.
module systolic_tile_ctrl #(
  parameter int N      = 2,
  parameter int ROWS_W = 8,
  localparam int AW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        cfg_mode,
  input  logic [ROWS_W-1:0] cfg_rows,
  output logic              busy,
  output logic              done,
  output logic [1:0]        sys_mode,
  output logic              pe_enabled,
  output logic              w_rd_en,
  output logic [AW-1:0]     w_rd_addr,
  output logic              accept_w,
  output logic              in_rd_en,
  output logic [ROWS_W-1:0] in_rd_addr,
  output logic              valid,
  output logic              switch
);
  localparam logic [ROWS_W-1:0] LOAD_LAST  = ROWS_W'(N - 1);
  localparam logic [ROWS_W-1:0] DRAIN_LAST = ROWS_W'(2 * N - 2);
  localparam logic [AW-1:0]     W_TOP      = AW'(N - 1);
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;
  state_t            state;
  logic [ROWS_W-1:0] cnt;
  logic [ROWS_W-1:0] rows;
  // Outputs are set for the state being entered, so every output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rows       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sys_mode   <= 2'b00;
      pe_enabled <= 1'b0;
      w_rd_en    <= 1'b0;
      w_rd_addr  <= '0;
      accept_w   <= 1'b0;
      in_rd_en   <= 1'b0;
      in_rd_addr <= '0;
      valid      <= 1'b0;
      switch     <= 1'b0;
    end else if (state != IDLE && (abort || state == DONE)) begin
      state      <= IDLE;
      cnt        <= '0;
      rows       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sys_mode   <= 2'b00;
      pe_enabled <= 1'b0;
      w_rd_en    <= 1'b0;
      w_rd_addr  <= '0;
      accept_w   <= 1'b0;
      in_rd_en   <= 1'b0;
      in_rd_addr <= '0;
      valid      <= 1'b0;
      switch     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && !abort && cfg_rows != '0) begin
          state      <= LOAD_W;
          rows       <= cfg_rows;
          sys_mode   <= cfg_mode;
          cnt        <= LOAD_LAST;
          busy       <= 1'b1;
          pe_enabled <= 1'b1;
          w_rd_en    <= 1'b1;
          accept_w   <= 1'b1;
          w_rd_addr  <= W_TOP;
        end
        LOAD_W: if (cnt == '0) begin
          state      <= STREAM;
          cnt        <= rows - 1'b1;
          w_rd_en    <= 1'b0;
          accept_w   <= 1'b0;
          w_rd_addr  <= '0;
          in_rd_en   <= 1'b1;
          in_rd_addr <= '0;
          valid      <= 1'b1;
          switch     <= 1'b1;
        end else begin
          cnt        <= cnt - 1'b1;
          w_rd_addr  <= w_rd_addr - 1'b1;
        end
        STREAM: begin
          switch <= 1'b0;
          if (cnt == '0) begin
            state      <= DRAIN;
            cnt        <= DRAIN_LAST;
            in_rd_en   <= 1'b0;
            in_rd_addr <= '0;
            valid      <= 1'b0;
          end else begin
            cnt        <= cnt - 1'b1;
            in_rd_addr <= in_rd_addr + 1'b1;
          end
        end
        DRAIN: if (cnt == '0) begin
          state <= DONE;
          done  <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// tb_systolic_tile_ctrl: directed checks of tile sequencing for N=2 and N=4 instances.
module tb_systolic_tile_ctrl;
  logic       clk, rst_n, start, abort;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_rows;
  logic       busy, done, pe_enabled, w_rd_en, w_rd_addr, accept_w, in_rd_en, valid, switch;
  logic [1:0] sys_mode;
  logic [7:0] in_rd_addr;
  logic       busy4, done4, pe4, wen4, acc4, inen4, valid4, sw4;
  logic [1:0] waddr4, mode4;
  logic [7:0] inaddr4;
  int errors = 0, checks = 0;
  logic [18:0] obs, t2 [10];

  systolic_tile_ctrl #(.N(2), .ROWS_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_mode(cfg_mode),
    .cfg_rows(cfg_rows), .busy(busy), .done(done), .sys_mode(sys_mode),
    .pe_enabled(pe_enabled), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
    .accept_w(accept_w), .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
    .valid(valid), .switch(switch));

  systolic_tile_ctrl #(.N(4), .ROWS_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_mode(cfg_mode),
    .cfg_rows(cfg_rows), .busy(busy4), .done(done4), .sys_mode(mode4),
    .pe_enabled(pe4), .w_rd_en(wen4), .w_rd_addr(waddr4),
    .accept_w(acc4), .in_rd_en(inen4), .in_rd_addr(inaddr4),
    .valid(valid4), .switch(sw4));

  // Addresses are only defined while their read strobe is up (or in IDLE, where all is 0).
  assign obs = {busy, done, pe_enabled, w_rd_en, accept_w, (w_rd_en | ~busy) & w_rd_addr,
                in_rd_en, valid, switch, sys_mode, (in_rd_en | ~busy) ? in_rd_addr : 8'd0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] pk(input int b, d, p, we, a, wa, ie, v, s, m, ia);
    return {b[0], d[0], p[0], we[0], a[0], wa[0], ie[0], v[0], s[0], m[1:0], ia[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic go(input logic [1:0] m, input logic [7:0] r);
    cfg_mode = m;
    cfg_rows = r;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int dn, bz, k, bad, first_v, nval, last_a, done_at;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_mode = 2'b00; cfg_rows = 8'd0;
    t2[0] = pk(1,0,1,1,1,1,0,0,0,2,0);
    t2[1] = pk(1,0,1,1,1,0,0,0,0,2,0);
    t2[2] = pk(1,0,1,0,0,0,1,1,1,2,0);
    t2[3] = pk(1,0,1,0,0,0,1,1,0,2,1);
    t2[4] = pk(1,0,1,0,0,0,1,1,0,2,2);
    t2[5] = pk(1,0,1,0,0,0,0,0,0,2,0);
    t2[6] = pk(1,0,1,0,0,0,0,0,0,2,0);
    t2[7] = pk(1,0,1,0,0,0,0,0,0,2,0);
    t2[8] = pk(1,1,1,0,0,0,0,0,0,2,0);
    t2[9] = pk(0,0,0,0,0,0,0,0,0,0,0);
    tick();
    rst_n = 1'b1;
    chk("reset_state", 32'(obs), 0);
    // Test 2: full tile, mode 10, M=3.
    go(2'b10, 8'd3);
    cfg_mode = 2'b01;
    cfg_rows = 8'd7;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("tile_c%0d", i + 1), 32'(obs), 32'(t2[i]));
      tick();
    end
    // Test 1: async reset mid-STREAM.
    do_reset();
    go(2'b11, 8'd3);
    tick(); tick();
    chk("pre_rst_valid", 32'(valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_n2", 32'(obs), 0);
    chk("rst_async_n4", 32'({busy4, pe4, acc4, valid4}), 0);
    tick();
    rst_n = 1'b1;
    dn = 0; bz = 0;
    for (int i = 0; i < 12; i++) begin tick(); dn += int'(done); bz += int'(busy); end
    chk("rst_no_done", 32'(dn), 0);
    chk("rst_idle", 32'(bz), 0);
    // Test 3: zero rows ignored, start while busy ignored.
    go(2'b01, 8'd0);
    dn = 0; bz = 0;
    for (int i = 0; i < 8; i++) begin dn += int'(done); bz += int'(busy); tick(); end
    chk("rows0_busy", 32'(bz), 0);
    chk("rows0_done", 32'(dn), 0);
    do_reset();
    go(2'b01, 8'd1);
    tick(); tick();
    go(2'b11, 8'd5);
    chk("busy_mode_hold", 32'(sys_mode), 1);
    dn = 0;
    for (int i = 0; i < 14; i++) begin dn += int'(done); tick(); end
    chk("busy_start_one_done", 32'(dn), 1);
    chk("busy_start_idle", 32'(busy), 0);
    // Test 4: abort in LOAD_W cycle 2, then start+abort in IDLE.
    do_reset();
    go(2'b10, 8'd3);
    tick();
    chk("abort_pre_acc", 32'(accept_w), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", 32'(obs), 0);
    chk("abort_idle_n4", 32'({busy4, pe4}), 0);
    dn = 0;
    for (int i = 0; i < 10; i++) begin dn += int'(done) + int'(done4); tick(); end
    chk("abort_no_done", 32'(dn), 0);
    abort = 1'b1;
    go(2'b10, 8'd3);
    abort = 1'b0;
    chk("start_abort_idle", 32'({busy, busy4}), 0);
    // Test 5: start held high gives back-to-back tiles.
    do_reset();
    cfg_mode = 2'b01; cfg_rows = 8'd1; start = 1'b1;
    dn = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 9) start = 1'b0;
      dn += int'(done);
      if (i == 7) chk("b2b_done1", 32'(done), 1);
      if (i == 8) chk("b2b_gap_idle", 32'(busy), 0);
      if (i == 9) chk("b2b_restart", 32'({busy, accept_w}), 3);
      if (i == 15) chk("b2b_done2", 32'(done), 1);
    end
    chk("b2b_two_dones", 32'(dn), 2);
    // Test 6: N=4, M=255.
    do_reset();
    go(2'b00, 8'd255);
    chk("n4_first_waddr", 32'(waddr4), 3);
    bad = 0; first_v = -1; nval = 0; last_a = -1; done_at = -1; k = 0;
    for (int i = 1; i <= 270; i++) begin
      if (valid4) begin
        if (first_v < 0) first_v = i;
        if (int'(inaddr4) != k) bad++;
        k++; nval++; last_a = int'(inaddr4);
      end
      if (done4 && done_at < 0) done_at = i;
      tick();
    end
    chk("n4_first_valid", 32'(first_v), 5);
    chk("n4_valid_count", 32'(nval), 255);
    chk("n4_addr_seq", 32'(bad), 0);
    chk("n4_last_addr", 32'(last_a), 254);
    chk("n4_done_cycle", 32'(done_at), 267);
    chk("n4_end_idle", 32'(busy4), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
